// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the alu: register file, MIPS opcode/funct decode and one
// registered output slot with a valid/ready handshake on both sides.
module alu_issue_stage #(
    parameter int DATA_W    = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              aluSrc,
    output logic [3:0]        aluCtrl,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] imm,
    output logic [4:0]        dest,
    output logic              reg_write,
    output logic              illegal
);

    localparam logic [3:0] C_ADD = 4'b0000;
    localparam logic [3:0] C_SUB = 4'b0010;
    localparam logic [3:0] C_AND = 4'b0100;
    localparam logic [3:0] C_OR  = 4'b0101;
    localparam logic [3:0] C_SLL = 4'b0110;
    localparam logic [3:0] C_SRL = 4'b0111;
    localparam logic [3:0] C_SLT = 4'b1000;
    localparam logic [3:0] C_BEQ = 4'b1001;
    localparam logic [3:0] C_BNE = 4'b1010;

    logic [DATA_W-1:0] r_regs [0:31];
    logic              r_out_valid;
    logic              r_alu_src;
    logic [3:0]        r_alu_ctrl;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [DATA_W-1:0] r_imm;
    logic [4:0]        r_dest;
    logic              r_reg_write;
    logic              r_illegal;

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic [4:0]        w_shamt;
    logic [5:0]        w_funct;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_capture;

    logic              w_illegal;
    logic [3:0]        w_ctrl;
    logic              w_src;
    logic [DATA_W-1:0] w_d1;
    logic [DATA_W-1:0] w_d2;
    logic [DATA_W-1:0] w_imm;
    logic [4:0]        w_dest;
    logic              w_rw;

    assign w_opcode  = in_instr[31:26];
    assign w_rs      = in_instr[25:21];
    assign w_rt      = in_instr[20:16];
    assign w_rd      = in_instr[15:11];
    assign w_shamt   = in_instr[10:6];
    assign w_funct   = in_instr[5:0];
    assign w_imm16   = in_instr[15:0];
    assign w_sext    = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
    assign w_zext    = {{(DATA_W-16){1'b0}}, w_imm16};
    assign in_ready  = !r_out_valid | out_ready;
    assign w_capture = in_valid & in_ready;

    // Operand read with R0 hard-wired to zero and optional write-back forwarding
    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_rs == 5'd0) begin
            w_rs_val = '0;
        end else if (BYPASS_EN && wb_en && (wb_addr == w_rs)) begin
            w_rs_val = wb_data;
        end else begin
            w_rs_val = r_regs[w_rs];
        end
        if (w_rt == 5'd0) begin
            w_rt_val = '0;
        end else if (BYPASS_EN && wb_en && (wb_addr == w_rt)) begin
            w_rt_val = wb_data;
        end else begin
            w_rt_val = r_regs[w_rt];
        end
    end

    // Instruction decode into alu controls, operands and destination
    always_comb begin
        w_illegal = 1'b0;
        w_ctrl    = C_ADD;
        w_src     = 1'b0;
        w_d1      = w_rs_val;
        w_d2      = w_rt_val;
        w_imm     = '0;
        w_dest    = 5'd0;
        w_rw      = 1'b0;
        case (w_opcode)
            6'h00: begin
                w_dest = w_rd;
                w_rw   = 1'b1;
                case (w_funct)
                    6'h20, 6'h21: w_ctrl = C_ADD;
                    6'h22, 6'h23: w_ctrl = C_SUB;
                    6'h24:        w_ctrl = C_AND;
                    6'h25:        w_ctrl = C_OR;
                    6'h2A:        w_ctrl = C_SLT;
                    6'h00: begin
                        w_ctrl = C_SLL;
                        w_d1   = w_rt_val;
                        w_d2   = {{(DATA_W-5){1'b0}}, w_shamt};
                    end
                    6'h02: begin
                        w_ctrl = C_SRL;
                        w_d1   = w_rt_val;
                        w_d2   = {{(DATA_W-5){1'b0}}, w_shamt};
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: begin
                w_src  = 1'b1;
                w_dest = w_rt;
                w_rw   = 1'b1;
                case (w_opcode)
                    6'h0A:   begin w_ctrl = C_SLT; w_imm = w_sext; end
                    6'h0C:   begin w_ctrl = C_AND; w_imm = w_zext; end
                    6'h0D:   begin w_ctrl = C_OR;  w_imm = w_zext; end
                    default: begin w_ctrl = C_ADD; w_imm = w_sext; end
                endcase
            end
            6'h04: begin w_ctrl = C_BEQ; w_imm = w_sext; end
            6'h05: begin w_ctrl = C_BNE; w_imm = w_sext; end
            default: w_illegal = 1'b1;
        endcase
        // Unsupported encodings still issue, but as an inert op
        if (w_illegal) begin
            w_ctrl = C_ADD;
            w_src  = 1'b0;
            w_d1   = '0;
            w_d2   = '0;
            w_imm  = '0;
            w_dest = 5'd0;
            w_rw   = 1'b0;
        end else begin
            w_ctrl = w_ctrl;
        end
    end

    // Register file write port; R0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Issue slot: flush beats capture, capture beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_ctrl  <= 4'b0000;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_dest      <= 5'd0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_alu_src   <= w_src;
            r_alu_ctrl  <= w_ctrl;
            r_data1     <= w_d1;
            r_data2     <= w_d2;
            r_imm       <= w_imm;
            r_dest      <= w_dest;
            r_reg_write <= w_rw;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign aluSrc    = r_alu_src;
    assign aluCtrl   = r_alu_ctrl;
    assign data1     = r_data1;
    assign data2     = r_data2;
    assign imm       = r_imm;
    assign dest      = r_dest;
    assign reg_write = r_reg_write;
    assign illegal   = r_illegal;

endmodule
